// File: rtl/mdio_initiator.sv
// Clause 22 MDIO station-management master: serializes 64-bit read/write frames
// on MDC/MDIO and captures the PHY's turnaround/read data.
module mdio_initiator #(
  parameter int unsigned MDC_HALF = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        op_write,
  input  logic [4:0]  phy_addr,
  input  logic [4:0]  reg_addr,
  input  logic [15:0] wr_data,
  output logic        mdc,
  output logic        mdio_out,
  output logic        mdio_oe,
  input  logic        mdio_in,
  output logic        busy,
  output logic        mdio_done,
  output logic [15:0] rd_data,
  output logic        rd_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREAMBLE,
    S_HDR,
    S_TA,
    S_DATA,
    S_DONE
  } state_t;

  localparam logic [7:0] PH_LAST = 8'(MDC_HALF - 1);

  state_t      r_state;
  logic [5:0]  r_bit;
  logic [7:0]  r_ph;
  logic [62:0] r_frame;
  logic        r_wr;
  logic [15:0] r_shift;
  logic        r_err_cap;
  logic        r_mdc;
  logic        r_out;
  logic        r_oe;
  logic        r_busy;
  logic        r_done;
  logic [15:0] r_rd_data;
  logic        r_rd_err;

  logic       w_last_phase;
  logic [5:0] w_nbit;

  assign w_last_phase = (r_ph == PH_LAST);
  assign w_nbit       = r_bit + 6'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_bit     <= '0;
      r_ph      <= '0;
      r_frame   <= '1;
      r_wr      <= 1'b0;
      r_shift   <= '0;
      r_err_cap <= 1'b0;
      r_mdc     <= 1'b0;
      r_out     <= 1'b1;
      r_oe      <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_rd_data <= '0;
      r_rd_err  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          r_state <= S_IDLE;
          if (start) begin
            // Whole frame is latched at launch; bit 0 (a preamble one) goes out now,
            // the remaining 63 bits shift out MSB first.
            r_frame <= {31'h7FFF_FFFF, 2'b01, (op_write ? 2'b01 : 2'b10), phy_addr, reg_addr,
                        (op_write ? 2'b10 : 2'b11), (op_write ? wr_data : 16'hFFFF)};
            r_wr    <= op_write;
            r_state <= S_PREAMBLE;
            r_bit   <= '0;
            r_ph    <= '0;
            r_mdc   <= 1'b0;
            r_out   <= 1'b1;
            r_oe    <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        default: begin
          if (!w_last_phase) begin
            r_ph <= r_ph + 8'd1;
          end else begin
            r_ph <= '0;
            if (!r_mdc) begin
              r_mdc <= 1'b1;
              if (!r_wr) begin
                if (r_bit == 6'd47)
                  r_err_cap <= mdio_in;
                else if (r_bit >= 6'd48)
                  r_shift <= {r_shift[14:0], mdio_in};
              end
            end else begin
              r_mdc <= 1'b0;
              if (r_bit == 6'd63) begin
                r_state  <= S_DONE;
                r_busy   <= 1'b0;
                r_done   <= 1'b1;
                r_oe     <= 1'b0;
                r_out    <= 1'b1;
                r_rd_err <= r_wr ? 1'b0 : r_err_cap;
                if (!r_wr)
                  r_rd_data <= r_shift;
              end else begin
                r_bit   <= w_nbit;
                r_out   <= r_frame[62];
                r_frame <= {r_frame[61:0], 1'b1};
                r_oe    <= r_wr || (w_nbit < 6'd46);
                if (w_nbit == 6'd32)
                  r_state <= S_HDR;
                else if (w_nbit == 6'd46)
                  r_state <= S_TA;
                else if (w_nbit == 6'd48)
                  r_state <= S_DATA;
              end
            end
          end
        end
      endcase
    end
  end

  assign mdc       = r_mdc;
  assign mdio_out  = r_out;
  assign mdio_oe   = r_oe;
  assign busy      = r_busy;
  assign mdio_done = r_done;
  assign rd_data   = r_rd_data;
  assign rd_err    = r_rd_err;

endmodule

// File: tb/tb_mdio_initiator.sv
// Scoreboard bench for mdio_initiator: random read/write frames against a frame-level
// model, a PHY responder model, plus a MDC_HALF=1 instance for timing.
module tb_mdio_initiator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        start_b = 1'b0;
  logic        op_write = 1'b0;
  logic [4:0]  phy_addr = '0;
  logic [4:0]  reg_addr = '0;
  logic [15:0] wr_data = '0;
  logic        mdio_in = 1'b1;
  logic        mdc, mdio_out, mdio_oe, busy, mdio_done, rd_err;
  logic [15:0] rd_data;
  logic        mdc_b, mdio_out_b, mdio_oe_b, busy_b, mdio_done_b, rd_err_b;
  logic [15:0] rd_data_b;

  mdio_initiator #(.MDC_HALF(2)) dut (
    .clk(clk), .reset(reset), .start(start), .op_write(op_write),
    .phy_addr(phy_addr), .reg_addr(reg_addr), .wr_data(wr_data),
    .mdc(mdc), .mdio_out(mdio_out), .mdio_oe(mdio_oe), .mdio_in(mdio_in),
    .busy(busy), .mdio_done(mdio_done), .rd_data(rd_data), .rd_err(rd_err)
  );

  mdio_initiator #(.MDC_HALF(1)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .op_write(op_write),
    .phy_addr(phy_addr), .reg_addr(reg_addr), .wr_data(wr_data),
    .mdc(mdc_b), .mdio_out(mdio_out_b), .mdio_oe(mdio_oe_b), .mdio_in(1'b1),
    .busy(busy_b), .mdio_done(mdio_done_b), .rd_data(rd_data_b), .rd_err(rd_err_b)
  );

  typedef struct {
    logic [63:0] frame;
    logic [63:0] oe;
    int unsigned done_cyc;
    logic [15:0] rd;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  int          total = 0;
  int          bad = 0;
  int unsigned cyc = 0;
  logic [15:0] last_rd = '0;
  logic        phy_en = 1'b0;
  logic [15:0] phy_data = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] mk_frame(input logic w, input logic [4:0] pa,
                                           input logic [4:0] ra, input logic [15:0] d);
    return {32'hFFFF_FFFF, 2'b01, (w ? 2'b01 : 2'b10), pa, ra,
            (w ? 2'b10 : 2'b11), (w ? d : 16'hFFFF)};
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // PHY responder: drives turnaround 0 and read data, updating after MDC falls.
  initial begin : phy_model
    logic        ph_prev;
    int unsigned ph_bit;
    ph_prev = 1'b0;
    ph_bit  = 0;
    forever begin
      @(negedge clk);
      if (reset || !busy) begin
        ph_bit  = 0;
        mdio_in = 1'b1;
      end else begin
        if (mdc && !ph_prev) ph_bit++;
        if (!mdc && ph_prev) begin
          if (!phy_en) mdio_in = 1'b1;
          else if (ph_bit == 47) mdio_in = 1'b0;
          else if (ph_bit >= 48 && ph_bit <= 63) mdio_in = phy_data[63 - ph_bit];
          else mdio_in = 1'b1;
        end
      end
      ph_prev = mdc;
    end
  end

  // Monitor: captures bits at MDC rising edges, checks completions against the queue.
  initial begin : monitor_a
    logic [63:0] cap_f, cap_oe;
    int unsigned cap_n;
    logic        p_mdc, p_out, p_oe, p_busy, p_done;
    exp_t        e;
    cap_f = '0; cap_oe = '0; cap_n = 0;
    p_mdc = 1'b0; p_out = 1'b1; p_oe = 1'b0; p_busy = 1'b0; p_done = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        cap_n = 0;
        p_mdc = 1'b0; p_out = 1'b1; p_oe = 1'b0; p_busy = 1'b0; p_done = 1'b0;
      end else begin
        if (mdio_out !== p_out || mdio_oe !== p_oe)
          chk("io_change_at_bit_start", {63'b0, (p_mdc && !mdc) || (busy && !p_busy)}, 64'd1);
        if (mdc && !p_mdc) begin
          if (cap_n < 64) begin
            cap_f[63 - cap_n]  = mdio_out;
            cap_oe[63 - cap_n] = mdio_oe;
          end
          cap_n++;
        end
        if (mdio_done) begin
          chk("done_expected", {63'b0, exp_q.size() != 0}, 64'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("bit_count", 64'(cap_n), 64'd64);
            chk("frame_bits", cap_f, e.frame);
            chk("frame_oe", cap_oe, e.oe);
            chk("done_cycle", 64'(cyc), 64'(e.done_cyc));
            chk("rd_data", 64'(rd_data), 64'(e.rd));
            chk("rd_err", 64'(rd_err), 64'(e.err));
            chk("done_state", {60'b0, busy, mdc, mdio_oe, mdio_out}, 64'h1);
            chk("done_single", 64'(p_done), 64'd0);
          end
          cap_n = 0;
        end
        p_mdc = mdc; p_out = mdio_out; p_oe = mdio_oe; p_busy = busy; p_done = mdio_done;
      end
    end
  end

  logic [63:0] b_frame = '0;
  int unsigned b_done_cyc = 0;
  int          b_done_cnt = 0;

  initial begin : monitor_b
    logic [63:0] cap_f;
    int unsigned cap_n;
    logic        p_mdc, p_busy;
    cap_f = '0; cap_n = 0; p_mdc = 1'b0; p_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (busy_b && p_busy) chk("b_mdc_toggle", {63'b0, mdc_b != p_mdc}, 64'd1);
        if (mdc_b && !p_mdc) begin
          if (cap_n < 64) cap_f[63 - cap_n] = mdio_out_b;
          cap_n++;
        end
        if (mdio_done_b) begin
          b_done_cnt++;
          chk("b_bit_count", 64'(cap_n), 64'd64);
          chk("b_frame_bits", cap_f, b_frame);
          chk("b_done_cycle", 64'(cyc), 64'(b_done_cyc));
          cap_n = 0;
        end
      end
      p_mdc = mdc_b; p_busy = busy_b;
    end
  end

  // Called #1 after a clk rising edge; returns the launch cycle T.
  task automatic issue(input logic w, input logic [4:0] pa, input logic [4:0] ra,
                       input logic [15:0] d, input logic en, input logic [15:0] pd,
                       output int unsigned t);
    exp_t e;
    phy_en   = en;
    phy_data = pd;
    op_write = w;
    phy_addr = pa;
    reg_addr = ra;
    wr_data  = d;
    start    = 1'b1;
    t        = cyc;
    if (!w) last_rd = en ? pd : 16'hFFFF;
    e.frame    = mk_frame(w, pa, ra, d);
    e.oe       = w ? '1 : {{46{1'b1}}, {18{1'b0}}};
    e.done_cyc = t + 1 + 128 * 2;
    e.rd       = last_rd;
    e.err      = !w && !en;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_after_start", 64'(busy), 64'd1);
  endtask

  task automatic wait_cycles(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin : stim
    int unsigned t, t2;
    logic [21:0] rst_vals;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_values", 64'({mdc, mdio_out, mdio_oe, busy, mdio_done, rd_err, rd_data}),
        64'({1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000}));
    @(posedge clk);
    #1;
    reset = 1'b0;
    wait_cycles(2);

    issue(1'b1, 5'd1, 5'd5, 16'hABCD, 1'b0, 16'h0000, t);
    wait_cycles(262);
    issue(1'b0, 5'd2, 5'd8, 16'h0000, 1'b1, 16'hFEED, t);
    wait_cycles(262);
    issue(1'b0, 5'($urandom), 5'($urandom), 16'($urandom), 1'b0, 16'h0000, t);
    wait_cycles(262);

    // Busy rejection, then a second start exactly in the DONE cycle.
    issue(1'b1, 5'($urandom), 5'($urandom), 16'($urandom), 1'b1, 16'($urandom), t);
    wait_cycles(50);
    op_write = 1'b0; phy_addr = ~phy_addr; reg_addr = ~reg_addr; wr_data = ~wr_data;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    while (cyc < t + 257) begin
      @(posedge clk);
      #1;
    end
    chk("done_before_b2b", 64'(mdio_done), 64'd1);
    issue(1'b0, 5'($urandom), 5'($urandom), 16'($urandom), 1'b1, 16'($urandom), t2);
    wait_cycles(262);

    // Reset inside bit 40 of a write.
    issue(1'b1, 5'($urandom), 5'($urandom), 16'($urandom), 1'b1, 16'($urandom), t);
    while (cyc < t + 1 + 40 * 4 + 1) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    void'(exp_q.pop_back());
    last_rd = 16'h0000;
    @(negedge clk);
    rst_vals = {mdc, mdio_out, mdio_oe, busy, mdio_done, rd_err, rd_data};
    chk("after_abort", 64'(rst_vals), 64'({1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000}));
    @(posedge clk);
    #1;
    issue(1'b0, 5'($urandom), 5'($urandom), 16'($urandom), 1'b1, 16'($urandom), t);
    wait_cycles(262);

    for (int i = 0; i < 5; i++) begin
      issue(1'($urandom), 5'($urandom), 5'($urandom), 16'($urandom),
            1'($urandom_range(0, 3) != 0), 16'($urandom), t);
      wait_cycles(258 + $urandom_range(0, 4));
    end
    wait_cycles(10);

    // MDC_HALF=1 instance: same write as the first frame.
    op_write = 1'b1; phy_addr = 5'd1; reg_addr = 5'd5; wr_data = 16'hABCD;
    b_frame    = mk_frame(1'b1, 5'd1, 5'd5, 16'hABCD);
    b_done_cyc = cyc + 1 + 128;
    start_b    = 1'b1;
    @(posedge clk);
    #1;
    start_b = 1'b0;
    wait_cycles(140);

    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    chk("b_done_count", 64'(b_done_cnt), 64'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
